// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   uart_state_t          - frame state encoding
//   UART_CLKS_PER_BIT_DEF - default clocks per bit (25 MHz / 115200 baud)
//   STAT_*                - bit positions of the flags in the 16-bit status word
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT_DEF = 217;

    localparam int STAT_FULL = 15;
    localparam int STAT_IDLE = 14;
    localparam int STAT_OVF  = 13;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte queue for the UART transmitter. Synchronous reset.
// A pop is evaluated before a push on the same edge, so a push into a full
// queue that is being popped on that edge is accepted.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   push, din     - enqueue strobe and byte
//   pop, dout     - dequeue strobe and head byte (valid while !empty)
//   full, empty   - queue flags
//   count         - occupancy, 0..DEPTH
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter, LSB first, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Bytes written with load are queued in a FIFO and sent back to back.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   load, in   - write strobe; in[7:0] is queued, in[15:8] is ignored
//   TX         - registered serial output, idles high
//   out        - status: [15] full, [14] idle, [13] sticky overflow,
//                [12:8] occupancy, [7:0] zero
// Build option: UART_TX_PARITY_EN inserts an even-parity bit after the data.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (TX=0)
// ST_DATA   | 8 data bits, TX=shift[0], shift right each bit end
// ST_PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit (TX=1); pops the next byte without a gap
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    output logic        TX,
    output logic [15:0] out
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_d;
    logic        baud_end;
    logic        pop;
    logic        ovf_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count;

    logic        unused_in_hi;
    assign unused_in_hi = ^in[15:8];

`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (load),
        .din   (in[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d  = baud_q + 8'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // next frame starts on this edge: no idle gap
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        bit_d   = '0;
                        state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^fifo_dout;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // TX is registered, so it is derived from the state being entered
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            TX      <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            TX      <= tx_d;
            if (load && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        out            = '0;
        out[STAT_FULL] = fifo_full;
        out[STAT_IDLE] = (state_q == ST_IDLE) && fifo_empty;
        out[STAT_OVF]  = ovf_q;
        out[12:8]      = 5'(fifo_count);
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    localparam int CPB = 217;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;
    localparam int TMO   = 3 * FRAME;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] in;
    logic        TX;
    logic [15:0] out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (in),
        .TX    (TX),
        .out   (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // frame: bit i is the i-th bit on the line (start, d0..d7, stop)
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // all tasks start and end just after a falling edge
    task automatic do_load(input logic [7:0] b, output int lc);
        load = 1'b1;
        in   = {8'hEE, b};
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        in   = 16'h0000;
        lc   = cyc;
    endtask

    task automatic cap_frame(output logic [10:0] bits, output int st, output bit ok);
        int n = 0;
        bits = '0;
        st   = 0;
        while (TX !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ok = (TX === 1'b0);
        if (!ok) return;
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        bits[0] = TX;
        for (int i = 1; i < NB; i++) begin
            repeat (CPB) @(negedge clk);
            bits[i] = TX;
        end
    endtask

    task automatic wait_idle(output int t, output bit ok);
        int n = 0;
        while (out[14] !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ok = (out[14] === 1'b1);
        t  = cyc;
    endtask

    function automatic logic [10:0] exp_bits(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    initial begin
        logic [10:0] bits;
        int          st, lc, t, zeros;
        bit          ok;
        int          starts[5];
        int          k;
        logic [15:0] exp_out[5];
        logic [7:0]  b;

        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'h07, 10'h20E, 1'b1};
        vecs[2] = '{8'h03, 10'h206, 1'b0};
        vecs[3] = '{8'hA3, 10'h346, 1'b0};
        exp_out[0] = 16'h0100;
        exp_out[1] = 16'h0100;
        exp_out[2] = 16'h0200;
        exp_out[3] = 16'h0300;
        exp_out[4] = 16'h8400;

        reset = 1'b1;
        load  = 1'b0;
        in    = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(negedge clk);
            check("idle_tx", 32'(TX), 32'd1);
            check("idle_out", 32'(out), 32'h4000);
        end

        // single frames from the vector table
        for (int i = 0; i < 4; i++) begin
            do_load(vecs[i].data, lc);
            check("load_status", 32'(out), 32'h0100);
            cap_frame(bits, st, ok);
            check("frame_found", 32'(ok), 32'd1);
            check("frame_bits", 32'(bits), 32'(exp_bits(vecs[i])));
            check("start_latency", 32'(st - lc), 32'd1);
            wait_idle(t, ok);
            check("idle_found", 32'(ok), 32'd1);
            check("idle_rise", 32'(t - lc), 32'(1 + FRAME));
            check("idle_status", 32'(out), 32'h4000);
        end

        // five back-to-back loads, then one into a full queue
        for (int i = 0; i < 5; i++) begin
            do_load(8'(i + 1), lc);
            if (i == 0) k = lc;
            check("burst_status", 32'(out), 32'(exp_out[i]));
        end
        do_load(8'h06, lc);
        check("ovf_status", 32'(out), 32'hA400);
        for (int i = 0; i < 5; i++) begin
            cap_frame(bits, st, ok);
            starts[i] = st;
            check("burst_found", 32'(ok), 32'd1);
            b = bits[8:1];
            check("burst_byte", 32'(b), 32'(i + 1));
            check("burst_start_bit", 32'(bits[0]), 32'd0);
            check("burst_stop_bit", 32'(bits[NB-1]), 32'd1);
        end
        for (int i = 2; i < 5; i++)
            check("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
        wait_idle(t, ok);
        check("burst_idle_found", 32'(ok), 32'd1);
        check("burst_idle_rise", 32'(t - k), 32'(1 + 5 * FRAME));
        check("burst_idle_status", 32'(out), 32'h6000);
        zeros = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (TX !== 1'b1) zeros++;
        end
        check("no_sixth_frame", 32'(zeros), 32'd0);

        // reset in the middle of the data bits, with a second byte queued
        do_load(8'hA3, lc);
        do_load(8'h5A, lc);
        repeat (3 * CPB) @(negedge clk);
        check("pre_reset_status", 32'(out), 32'h2100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_out", 32'(out), 32'h4000);
        zeros = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (TX !== 1'b1) zeros++;
        end
        check("no_residual_frame", 32'(zeros), 32'd0);
        check("post_reset_out", 32'(out), 32'h4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
